// File: rtl/adxl362_ctrl.sv
// rtl/adxl362_ctrl.sv - ADXL362 configuration and XYZ burst-read sequencer
// Drives a single-byte SPI master: two register writes after power-up, then periodic or interrupt-driven reads.
module adxl362_ctrl #(
  parameter int         STARTUP_CYCLES = 250000,
  parameter int         SAMPLE_PERIOD  = 500000,
  parameter int         CS_GAP_CYCLES  = 100,
  parameter int         BYTE_TIMEOUT   = 20000,
  parameter bit         USE_INT        = 1'b0,
  parameter logic [7:0] FILTER_CTL_VAL = 8'h13,
  parameter logic [7:0] POWER_CTL_VAL  = 8'h02
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        intIn,
  output logic        spiEnOut,
  output logic [7:0]  spiTxDataOut,
  output logic        spiCsOut,
  output logic        spiRdEnOut,
  input  logic [7:0]  spiRxDataIn,
  input  logic        spiRxRdyIn,
  output logic [15:0] xDataOut,
  output logic [15:0] yDataOut,
  output logic [15:0] zDataOut,
  output logic        sampleValidOut,
  output logic        cfgDoneOut,
  output logic        busyOut,
  output logic        errOut
);
  localparam int MAX_A = (STARTUP_CYCLES > CS_GAP_CYCLES) ? STARTUP_CYCLES : CS_GAP_CYCLES;
  localparam int MAX_B = (SAMPLE_PERIOD > BYTE_TIMEOUT) ? SAMPLE_PERIOD : BYTE_TIMEOUT;
  localparam int CW    = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  typedef enum logic [2:0] {ST_STARTUP, ST_CFG, ST_GAP, ST_IDLE, ST_RD} state_t;
  typedef enum logic [1:0] {PH_EN, PH_WAIT, PH_POP} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [2:0]    byte_q, byte_d;
  logic          cfg_idx_q, cfg_idx_d;
  logic          cfg_done_q, cfg_done_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic [2:0]    int_sync_q, int_sync_d;
  logic [7:0]    rx_q [6];
  logic [7:0]    rx_d [6];
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;

  logic       wrap, trig, last_byte, in_xfer;
  logic [2:0] rx_idx;
  logic [7:0] tx_byte;

  always_comb begin
    int_sync_d = {int_sync_q[1:0], intIn};
    wrap       = cfg_done_q && (per_q == CW'(SAMPLE_PERIOD - 1));
    per_d      = (!cfg_done_q || wrap) ? '0 : per_q + CW'(1);
    trig       = USE_INT ? (int_sync_q[1] & ~int_sync_q[2]) : wrap;
    in_xfer    = (state_q == ST_CFG) || (state_q == ST_RD);
    last_byte  = (state_q == ST_CFG) ? (byte_q == 3'd2) : (byte_q == 3'd7);
    rx_idx     = byte_q - 3'd2;
    if (state_q == ST_CFG) begin
      case (byte_q)
        3'd0:    tx_byte = 8'h0A;
        3'd1:    tx_byte = cfg_idx_q ? 8'h2D : 8'h2C;
        default: tx_byte = cfg_idx_q ? POWER_CTL_VAL : FILTER_CTL_VAL;
      endcase
    end else begin
      case (byte_q)
        3'd0:    tx_byte = 8'h0B;
        3'd1:    tx_byte = 8'h0E;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    cfg_idx_d    = cfg_idx_q;
    cfg_done_d   = cfg_done_q;
    err_d        = err_q;
    valid_d      = 1'b0;
    pend_d       = pend_q | trig;
    rx_d         = rx_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    spiEnOut     = 1'b0;
    spiRdEnOut   = 1'b0;
    spiTxDataOut = 8'h00;
    case (state_q)
      ST_STARTUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STARTUP_CYCLES - 1)) begin
          state_d = ST_CFG;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CS_GAP_CYCLES - 1)) begin
          state_d = cfg_done_q ? ST_IDLE : ST_CFG;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_RD;
          pend_d  = trig;
        end
      end
      ST_CFG, ST_RD: begin
        case (phase_q)
          PH_EN: begin
            spiEnOut     = 1'b1;
            spiTxDataOut = tx_byte;
            phase_d      = PH_WAIT;
            cnt_d        = '0;
          end
          PH_WAIT: begin
            if (spiRxRdyIn) begin
              // Command/address echo bytes are discarded; only the six data bytes are kept.
              if (state_q == ST_RD && byte_q >= 3'd2) rx_d[rx_idx] = spiRxDataIn;
              phase_d = PH_POP;
            end else if (cnt_q == CW'(BYTE_TIMEOUT - 1)) begin
              err_d   = 1'b1;
              state_d = ST_GAP;
              phase_d = PH_EN;
              byte_d  = 3'd0;
              cnt_d   = '0;
              if (state_q == ST_CFG) cfg_idx_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PH_POP: begin
            spiRdEnOut = 1'b1;
            if (last_byte) begin
              state_d = ST_GAP;
              phase_d = PH_EN;
              byte_d  = 3'd0;
              cnt_d   = '0;
              if (state_q == ST_CFG) begin
                cfg_idx_d = 1'b1;
                if (cfg_idx_q) cfg_done_d = 1'b1;
              end else begin
                x_d     = {rx_q[1], rx_q[0]};
                y_d     = {rx_q[3], rx_q[2]};
                z_d     = {rx_q[5], rx_q[4]};
                valid_d = 1'b1;
              end
            end else begin
              byte_d  = byte_q + 3'd1;
              phase_d = PH_EN;
            end
          end
          default: phase_d = PH_EN;
        endcase
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q    <= ST_STARTUP;
      phase_q    <= PH_EN;
      cnt_q      <= '0;
      per_q      <= '0;
      byte_q     <= 3'd0;
      cfg_idx_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      int_sync_q <= 3'b000;
      rx_q       <= '{default: 8'h00};
      x_q        <= 16'h0000;
      y_q        <= 16'h0000;
      z_q        <= 16'h0000;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      byte_q     <= byte_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_done_q <= cfg_done_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      int_sync_q <= int_sync_d;
      rx_q       <= rx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
    end
  end

  assign spiCsOut       = in_xfer;
  assign busyOut        = in_xfer || (state_q == ST_GAP);
  assign xDataOut       = x_q;
  assign yDataOut       = y_q;
  assign zDataOut       = z_q;
  assign sampleValidOut = valid_q;
  assign cfgDoneOut     = cfg_done_q;
  assign errOut         = err_q;
endmodule

// File: tb/tb_adxl362_ctrl.sv
// tb/tb_adxl362_ctrl.sv - directed bench for adxl362_ctrl, timer-triggered (g=0) and interrupt-triggered (g=1)
module tb_adxl362_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, int_in, rdy, en, cs, rd_en, valid, cfg_done, busy, err;
  logic [7:0]  txd [2];
  logic [7:0]  rxd [2];
  logic [15:0] xo [2];
  logic [15:0] yo [2];
  logic [15:0] zo [2];
  int errors = 0, checks = 0, cyc = 0, viol = 0;
  bit outst [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    adxl362_ctrl #(
      .STARTUP_CYCLES(10), .SAMPLE_PERIOD(2000), .CS_GAP_CYCLES(100),
      .BYTE_TIMEOUT(100), .USE_INT(g == 1)
    ) u_dut (
      .clkIn(clk), .rstIn(rst_n[g]), .intIn(int_in[g]),
      .spiEnOut(en[g]), .spiTxDataOut(txd[g]), .spiCsOut(cs[g]), .spiRdEnOut(rd_en[g]),
      .spiRxDataIn(rxd[g]), .spiRxRdyIn(rdy[g]),
      .xDataOut(xo[g]), .yDataOut(yo[g]), .zDataOut(zo[g]),
      .sampleValidOut(valid[g]), .cfgDoneOut(cfg_done[g]), .busyOut(busy[g]), .errOut(err[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Flags a new byte strobe while the previous byte has not yet been popped.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n[g] || !cs[g]) outst[g] <= 1'b0;
      else if (en[g]) begin
        if (outst[g]) viol <= viol + 1;
        outst[g] <= 1'b1;
      end else if (rd_en[g]) outst[g] <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_vec(input int g);
    return {1'b0, en[g], cs[g], rd_en[g], txd[g], xo[g], yo[g], zo[g],
            valid[g], cfg_done[g], busy[g], err[g]};
  endfunction

  task automatic wait_en(input int g, input int budget, output int w);
    w = -1;
    for (int i = 0; i < budget; i++) begin
      if (en[g]) begin
        w = i;
        return;
      end
      tick();
    end
  endtask

  task automatic serve(input int g, input logic [7:0] exp_tx, input logic [7:0] rx,
                       input int lat, input bit pulses, input string tag);
    int w;
    wait_en(g, 3000, w);
    check({tag, "_en"}, (w >= 0), 1);
    if (w < 0) return;
    check({tag, "_tx"}, txd[g], exp_tx);
    tick();
    for (int k = 1; k < lat; k++) begin
      if (pulses) int_in[g] = (k < 18) && ((k % 6) < 3);
      tick();
    end
    int_in[g] = 1'b0;
    rdy[g] = 1'b1;
    rxd[g] = rx;
    tick();
    check({tag, "_rden"}, rd_en[g], 1);
    tick();
    rdy[g] = 1'b0;
    rxd[g] = 8'h00;
  endtask

  // lat==0 selects a random per-byte latency; pulse_at names the byte whose wait carries intIn pulses.
  task automatic read_burst(input int g, input logic [47:0] d, input int lat,
                            input int pulse_at, input string tag);
    logic [7:0] rx, tx;
    int l;
    for (int b = 0; b < 8; b++) begin
      rx = (b >= 2) ? d[8*(b-2) +: 8] : 8'hFF;
      tx = (b == 0) ? 8'h0B : (b == 1) ? 8'h0E : 8'h00;
      l  = (lat == 0) ? int'($urandom_range(30, 1)) : lat;
      serve(g, tx, rx, l, (b == pulse_at), tag);
    end
    check({tag, "_valid"}, {valid[g], cs[g]}, 2'b10);
    check({tag, "_xyz"}, {xo[g], yo[g], zo[g]}, {d[15:0], d[31:16], d[47:32]});
    tick();
    check({tag, "_valid_1cyc"}, valid[g], 0);
  endtask

  task automatic startup_cfg(input int g, input string tag);
    int w;
    rst_n[g] = 1'b1;
    repeat (9) tick();
    check({tag, "_pre_en"}, en[g], 0);
    tick();
    check({tag, "_first_en"}, {en[g], cs[g], txd[g]}, {2'b11, 8'h0A});
    serve(g, 8'h0A, 8'hFF, 40, 1'b0, tag);
    serve(g, 8'h2C, 8'hFF, 40, 1'b0, tag);
    serve(g, 8'h13, 8'hFF, 40, 1'b0, tag);
    check({tag, "_cs_drop"}, {cs[g], busy[g], cfg_done[g]}, 3'b010);
    wait_en(g, 500, w);
    check({tag, "_gap"}, (w >= 100), 1);
    serve(g, 8'h0A, 8'hFF, 40, 1'b0, tag);
    serve(g, 8'h2D, 8'hFF, 40, 1'b0, tag);
    serve(g, 8'h02, 8'hFF, 40, 1'b0, tag);
    check({tag, "_done"}, {cfg_done[g], cs[g]}, 2'b10);
  endtask

  initial begin
    int w, t1, t2, t3, nvalid;
    logic [47:0] d;
    rst_n = 2'b00;
    int_in = 2'b00;
    rdy = 2'b00;
    rxd[0] = 8'h00;
    rxd[1] = 8'h00;
    repeat (3) tick();
    check("rst_outs0", out_vec(0), 0);
    check("rst_outs1", out_vec(1), 0);

    startup_cfg(0, "cfg0");
    wait_en(0, 3000, w);
    t1 = cyc;
    read_burst(0, 48'h9ABC_5678_1234, 40, -1, "rd1");
    check("rd1_const", {xo[0], yo[0], zo[0]}, 48'h1234_5678_9ABC);

    wait_en(0, 3000, w);
    t2 = cyc;
    check("period", t2 - t1, 2000);
    serve(0, 8'h0B, 8'hFF, 40, 1'b0, "to");
    serve(0, 8'h0E, 8'hFF, 40, 1'b0, "to");
    serve(0, 8'h00, 8'h11, 40, 1'b0, "to");
    serve(0, 8'h00, 8'h22, 40, 1'b0, "to");
    wait_en(0, 3000, w);
    check("to_en3", (w >= 0), 1);
    tick();
    repeat (99) tick();
    check("to_err_early", err[0], 0);
    tick();
    check("to_err", {err[0], cs[0], valid[0]}, 3'b100);
    check("to_hold", {xo[0], yo[0], zo[0]}, 48'h1234_5678_9ABC);
    nvalid = 0;
    repeat (150) begin
      tick();
      if (valid[0]) nvalid++;
    end
    check("to_no_valid", nvalid, 0);

    wait_en(0, 3000, w);
    t3 = cyc;
    check("period_after_to", t3 - t2, 2000);
    read_burst(0, 48'h0605_0403_0201, 40, -1, "rd3");
    check("err_sticky", err[0], 1);

    serve(0, 8'h0B, 8'hFF, 40, 1'b0, "rstmid");
    serve(0, 8'h0E, 8'hFF, 40, 1'b0, "rstmid");
    serve(0, 8'h00, 8'hAA, 40, 1'b0, "rstmid");
    serve(0, 8'h00, 8'hBB, 40, 1'b0, "rstmid");
    rst_n[0] = 1'b0;
    #1;
    check("rst_async", out_vec(0), 0);
    repeat (2) tick();
    startup_cfg(0, "recfg");
    rst_n[0] = 1'b0;

    startup_cfg(1, "cfg1");
    int_in[1] = 1'b1;
    tick();
    int_in[1] = 1'b0;
    read_burst(1, 48'h0123_4567_89AB, 40, 2, "int1");
    wait_en(1, 400, w);
    check("int_extra", (w >= 0), 1);
    read_burst(1, 48'hFEDC_BA98_7654, 40, -1, "int2");
    wait_en(1, 1000, w);
    check("int_collapse", (w < 0), 1);

    for (int b = 0; b < 125; b++) begin
      d = {16'($urandom()), 32'($urandom())};
      int_in[1] = 1'b1;
      tick();
      int_in[1] = 1'b0;
      read_burst(1, d, 0, -1, "rnd");
    end
    check("one_outstanding", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adxl362_ctrl.md
Name: adxl362_ctrl

Overview:
- Sequencer that sits between the board top level and the single-byte SPI master (spi_flash_single).
- After reset it waits for sensor power-up, then writes the ADXL362 configuration registers.
- It then repeatedly burst-reads XDATA_L..ZDATA_H (0x0E..0x13), either periodically or on the sensor data-ready interrupt.
- It presents each assembled X/Y/Z sample with a one-cycle valid strobe.

Parameters:
STARTUP_CYCLES, 250000, clkIn cycles to wait after reset release before the first SPI access (5 ms at 50 MHz).
SAMPLE_PERIOD, 500000, clkIn cycles between read bursts when USE_INT=0.
CS_GAP_CYCLES, 100, minimum clkIn cycles spiCsOut stays low between transactions.
BYTE_TIMEOUT, 20000, maximum clkIn cycles to wait for spiRxRdyIn after issuing a byte.
USE_INT, 0, 1 = trigger reads on rising edge of intIn; 0 = trigger on the SAMPLE_PERIOD timer.
FILTER_CTL_VAL, 8'h13, value written to register 0x2C.
POWER_CTL_VAL, 8'h02, value written to register 0x2D (measurement mode).

Ports:
clkIn  in  1  system clock
rstIn  in  1  asynchronous active-low reset
intIn  in  1  ADXL362 INT1 (data ready), asynchronous; 2-FF synchronised internally
spiEnOut  out  1  one-cycle strobe; SPI master captures spiTxDataOut
spiTxDataOut  out  8  byte to shift out on MOSI
spiCsOut  out  1  high = SPI master holds chip select asserted
spiRdEnOut  out  1  one-cycle strobe popping the received byte
spiRxDataIn  in  8  byte received on MISO
spiRxRdyIn  in  1  high while a received byte is available
xDataOut  out  16  X sample {XDATA_H, XDATA_L}
yDataOut  out  16  Y sample
zDataOut  out  16  Z sample
sampleValidOut  out  1  one-cycle strobe; x/y/zDataOut updated this cycle
cfgDoneOut  out  1  high once both configuration writes have completed
busyOut  out  1  high while spiCsOut high or a CS gap is running
errOut  out  1  sticky byte-timeout flag; cleared only by reset

Behaviour:
- Reset (rstIn=0, async): all outputs 0; data registers 0; state STARTUP; all counters 0.
- Byte exchange (XFER sub-sequence):
  - Cycle 0: spiEnOut=1 with spiTxDataOut valid.
  - Wait for spiRxRdyIn=1. On the first cycle it is seen, latch spiRxDataIn.
  - Next cycle: spiRdEnOut=1 for exactly one cycle.
  - The next byte's spiEnOut is issued no earlier than the cycle after spiRdEnOut.
  - Never more than one byte is outstanding.
- Timeout: the timeout counter restarts at each spiEnOut. If it reaches BYTE_TIMEOUT without spiRxRdyIn:
  - set errOut and drop spiCsOut;
  - enter GAP, then IDLE if cfgDoneOut=1, otherwise CFG with index reset to 0.
- spiCsOut:
  - Goes high in the same cycle as the first spiEnOut of a transaction.
  - Goes low the cycle after the last byte's spiRdEnOut.
  - A transaction always ends with a GAP state of CS_GAP_CYCLES.
- States:
  - STARTUP: count STARTUP_CYCLES, then go to CFG.
  - CFG: transaction {0x0A, addr, value}. Index 0 writes 0x2C/FILTER_CTL_VAL; index 1 writes 0x2D/POWER_CTL_VAL. Go to GAP. After index 1 completes, set cfgDoneOut=1.
  - GAP: count CS_GAP_CYCLES, then go to CFG if the config index < 2, else IDLE.
  - IDLE: wait for a trigger, then go to RD.
  - RD: transaction {0x0B, 0x0E, then six 0x00 dummy bytes}. Ignore bytes received during cmd/addr; the six data bytes land in XL, XH, YL, YH, ZL, ZH.
  - After ZH is latched, update all three outputs simultaneously and pulse sampleValidOut in the same cycle spiCsOut drops. Go to GAP.
- Triggers:
  - USE_INT=0: the period counter free-runs from cfgDoneOut rising and wraps at SAMPLE_PERIOD-1. A wrap during a transaction is held as a single pending flag, not counted; multiple wraps collapse to one read.
  - USE_INT=1: a synchronised intIn rising edge sets the pending flag; same collapse rule.
- Partial reads: a timeout mid-RD leaves x/y/zDataOut unchanged and emits no sampleValidOut.
- Reset mid-transaction: immediate return to STARTUP with all outputs 0; the full STARTUP delay is repeated.
- Widths: counters sized by $clog2 of the largest parameter; data outputs are raw two's-complement as sent by the sensor, not sign-manipulated.

Test Plan:
- Release reset with STARTUP_CYCLES=10 and a slave model returning rxRdy 40 cycles after each en -> first spiEnOut at cycle 10 with 0x0A. Bytes sent are 0A,2C,13 then gap ≥ CS_GAP_CYCLES, then 0A,2D,02; cfgDoneOut rises after the second write.
- USE_INT=0, SAMPLE_PERIOD=2000, slave returns 34,12,78,56,BC,9A in the data phase -> sent bytes 0B,0E,00×6. Result: sampleValidOut one cycle, x=0x1234, y=0x5678, z=0x9ABC; next burst starts 2000 cycles after the previous trigger.
- Slave never asserts rxRdy on the 3rd read byte with BYTE_TIMEOUT=100 -> errOut=1 at cycle 100 after that spiEnOut. spiCsOut low next cycle, no sampleValidOut, outputs keep the prior sample, and the next trigger reads normally.
- USE_INT=1, three intIn pulses during one read transaction -> exactly one additional read follows after the gap.
- Assert rstIn=0 mid-read (after byte 4) -> all outputs 0 asynchronously. After release, the STARTUP delay repeats and configuration is re-sent from 0x2C.
- Check one-byte-outstanding rule -> assertion: no spiEnOut between a spiEnOut and its matching spiRdEnOut over 1000 random-latency slave responses.
